// File: rtl/branch_predictor.sv
// Bimodal/gshare direction predictor with a direct-mapped tagged BTB and saturating stats.
// Lookup is combinational with zero latency; training lands on the next edge; always ready, no backpressure.
module branch_predictor #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_BITS   = 6,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int MODE       = 0,
    parameter int GHR_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    output logic [GHR_BITS-1:0]   pred_ghr,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_uncond,
    input  logic [GHR_BITS-1:0]   upd_ghr,
    input  logic                  upd_mispredict,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
    localparam logic [CTR_BITS-1:0] CTR_WNT    = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_WNT_P1 = {1'b1, {(CTR_BITS-1){1'b0}}};

    logic                  r_valid  [ENTRIES];
    logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
    logic [CTR_BITS-1:0]   r_ctr    [ENTRIES];
    logic [GHR_BITS-1:0]   r_ghr;
    logic [31:0]           r_stat_br;
    logic [31:0]           r_stat_mp;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic                w_if_hit;
    logic [IDX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0] w_upd_tag;
    logic                w_upd_hit;
    logic [CTR_BITS-1:0] w_ctr_cur;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic                w_upd_dir;
    logic                w_unused;

    // Lookup hashes with the live history, training with the snapshot carried down the pipe.
    assign w_if_idx  = (MODE == 1) ? (if_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr)) : if_pc[IDX_BITS+1:2];
    assign w_upd_idx = (MODE == 1) ? (upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_ghr)) : upd_pc[IDX_BITS+1:2];
    assign w_if_tag  = if_pc[IDX_BITS+1+TAG_BITS:IDX_BITS+2];
    assign w_upd_tag = upd_pc[IDX_BITS+1+TAG_BITS:IDX_BITS+2];

    assign w_if_hit    = !rst && r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_dir   = upd_taken | upd_uncond;

    assign pred_hit         = w_if_hit;
    assign pred_taken       = w_if_hit && r_ctr[w_if_idx][CTR_BITS-1];
    assign pred_target      = pred_taken ? r_target[w_if_idx] : if_pc + ADDR_WIDTH'(4);
    assign pred_ghr         = rst ? '0 : r_ghr;
    assign stat_branches    = rst ? '0 : r_stat_br;
    assign stat_mispredicts = rst ? '0 : r_stat_mp;

    assign w_unused = ^{if_pc, upd_pc, upd_ghr};

    always_comb begin
        w_ctr_cur  = r_ctr[w_upd_idx];
        w_ctr_next = w_ctr_cur;
        if (!w_upd_hit) begin
            w_ctr_next = upd_uncond ? CTR_MAX : (upd_taken ? CTR_WNT_P1 : CTR_WNT);
        end else if (upd_uncond) begin
            w_ctr_next = CTR_MAX;
        end else if (upd_taken && (w_ctr_cur != CTR_MAX)) begin
            w_ctr_next = w_ctr_cur + CTR_BITS'(1);
        end else if (!upd_taken && (w_ctr_cur != '0)) begin
            w_ctr_next = w_ctr_cur - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_WNT;
            end
            r_ghr     <= '0;
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (upd_valid) begin
            // Direct-mapped: a miss simply overwrites whatever lived at this index.
            if (!w_upd_hit) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= upd_target;
            end else if (upd_taken) begin
                r_target[w_upd_idx] <= upd_target;
            end
            r_ctr[w_upd_idx] <= w_ctr_next;
            r_ghr            <= GHR_BITS'({r_ghr, w_upd_dir});
            if (r_stat_br != 32'hFFFF_FFFF) begin
                r_stat_br <= r_stat_br + 32'd1;
            end
            if (upd_mispredict && (r_stat_mp != 32'hFFFF_FFFF)) begin
                r_stat_mp <= r_stat_mp + 32'd1;
            end
        end
    end
endmodule
